// File: rtl/chroma_key_unpack.sv
// Unpacks 128-bit groups of four ARGB pixels and chroma-keys each pixel against a background group.
// Latency 1; back-to-back groups with no bubble; optional key statistics under CHROMA_STATS_EN.
module chroma_key_unpack #(
  parameter logic [7:0] KEY_MARGIN = 8'd40,
  parameter logic [7:0] GREEN_MIN  = 8'd100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         validInput,
  input  logic [127:0] in,
  input  logic [127:0] bgIn,
  output logic         inReady,
  output logic [31:0]  pixel,
  output logic         validOutput,
  input  logic         readyOut,
  output logic         isKey,
  output logic [15:0]  keyCount
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]   r_state;
  logic [1:0]   r_lane;
  logic [127:0] r_fg;
  logic [127:0] r_bg;

  logic [31:0]  w_fg_px;
  logic [31:0]  w_bg_px;
  logic [8:0]   w_r_lim;
  logic [8:0]   w_b_lim;
  logic         w_key;
  logic         w_emit;
  logic         w_take;
  logic         w_accept;

  // Lane 0 is the most significant pixel of the group.
  always_comb begin
    w_fg_px = r_fg[127:96];
    w_bg_px = r_bg[127:96];
    case (r_lane)
      2'd0: begin w_fg_px = r_fg[127:96]; w_bg_px = r_bg[127:96]; end
      2'd1: begin w_fg_px = r_fg[95:64];  w_bg_px = r_bg[95:64];  end
      2'd2: begin w_fg_px = r_fg[63:32];  w_bg_px = r_bg[63:32];  end
      default: begin w_fg_px = r_fg[31:0]; w_bg_px = r_bg[31:0]; end
    endcase
  end

  // Margin sums are 9 bits so R or B near 255 can never wrap into a false key.
  assign w_r_lim = {1'b0, w_fg_px[23:16]} + {1'b0, KEY_MARGIN};
  assign w_b_lim = {1'b0, w_fg_px[7:0]}   + {1'b0, KEY_MARGIN};
  assign w_key   = (w_fg_px[15:8] >= GREEN_MIN)
                && ({1'b0, w_fg_px[15:8]} > w_r_lim)
                && ({1'b0, w_fg_px[15:8]} > w_b_lim);

  assign w_emit      = (r_state == S_EMIT);
  assign validOutput = w_emit;
  assign isKey       = w_emit & w_key;
  assign pixel       = w_emit ? (w_key ? w_bg_px : w_fg_px) : 32'h0;
  assign w_take      = w_emit & readyOut;
  assign inReady     = !w_emit || ((r_lane == 2'd3) && readyOut);
  assign w_accept    = validInput & inReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lane  <= 2'd0;
      r_fg    <= '0;
      r_bg    <= '0;
    end else if (w_accept) begin
      r_state <= S_EMIT;
      r_lane  <= 2'd0;
      r_fg    <= in;
      r_bg    <= bgIn;
    end else if (w_take) begin
      if (r_lane == 2'd3) begin
        r_state <= S_IDLE;
        r_lane  <= 2'd0;
      end else begin
        r_lane  <= r_lane + 2'd1;
      end
    end
  end

`ifdef CHROMA_STATS_EN
  logic [15:0] r_key_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_count <= 16'h0;
    end else if (w_take && w_key && (r_key_count != 16'hFFFF)) begin
      r_key_count <= r_key_count + 16'd1;
    end
  end

  assign keyCount = r_key_count;
`else
  assign keyCount = 16'h0;
`endif

endmodule

// File: tb/tb_chroma_key_unpack.sv
// Directed plus randomized checks of chroma_key_unpack against a per-pixel keying model.
module tb_chroma_key_unpack;

  logic         clk = 1'b0;
  logic         rst;
  logic         validInput;
  logic [127:0] in;
  logic [127:0] bgIn;
  logic         inReady;
  logic [31:0]  pixel;
  logic         validOutput;
  logic         readyOut;
  logic         isKey;
  logic [15:0]  keyCount;

  int checks   = 0;
  int failures = 0;
  int kc_model = 0;

  chroma_key_unpack dut (
    .clk(clk), .rst(rst), .validInput(validInput), .in(in), .bgIn(bgIn),
    .inReady(inReady), .pixel(pixel), .validOutput(validOutput),
    .readyOut(readyOut), .isKey(isKey), .keyCount(keyCount)
  );

  always #5 clk = ~clk;

  function automatic bit ref_key(input logic [31:0] px);
    int r, g, b;
    r = int'(px[23:16]);
    g = int'(px[15:8]);
    b = int'(px[7:0]);
    return (g >= 100) && (g > r + 40) && (g > b + 40);
  endfunction

  function automatic logic [31:0] rand_px();
    logic [31:0] p;
    p = $urandom;
    if ($urandom_range(0, 1) == 1) begin
      p[15:8]  = 8'($urandom_range(90, 255));
      p[23:16] = 8'($urandom_range(0, 80));
      p[7:0]   = 8'($urandom_range(0, 80));
    end
    return p;
  endfunction

  function automatic logic [127:0] rand_grp();
    return {rand_px(), rand_px(), rand_px(), rand_px()};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bump(input bit k);
`ifdef CHROMA_STATS_EN
    if (k && kc_model < 65535) kc_model++;
`else
    if (k) kc_model = kc_model;
`endif
  endtask

  // Called at a negedge with inputs already driven; checks the pixel shown for this lane.
  task automatic chk_lane(input logic [127:0] fg, input logic [127:0] bg, input int lane);
    logic [31:0] f, b;
    bit k;
    f = fg[127-32*lane -: 32];
    b = bg[127-32*lane -: 32];
    k = ref_key(f);
    #1;
    check($sformatf("vld_l%0d", lane), 32'(validOutput), 32'd1);
    check($sformatf("pix_l%0d", lane), pixel, k ? b : f);
    check($sformatf("key_l%0d", lane), 32'(isKey), 32'(k));
    check($sformatf("rdy_l%0d", lane), 32'(inReady), 32'((lane == 3) && readyOut));
    check($sformatf("kc_l%0d", lane), 32'(keyCount), 32'(kc_model));
    if (readyOut) bump(k);
  endtask

  task automatic start(input logic [127:0] fg, input logic [127:0] bg);
    validInput = 1'b1;
    in         = fg;
    bgIn       = bg;
    readyOut   = 1'b1;
    @(negedge clk);
  endtask

  // Emits one group; junk is offered on validInput while busy to confirm it is ignored.
  task automatic play_group(input logic [127:0] fg, input logic [127:0] bg,
                            input bit nvld, input logic [127:0] nfg, input logic [127:0] nbg,
                            input int stall_lane, input int stall_n);
    for (int lane = 0; lane < 4; lane++) begin
      if (lane < 3) begin
        validInput = 1'($urandom_range(0, 1));
        in         = {$urandom, $urandom, $urandom, $urandom};
        bgIn       = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        validInput = nvld;
        in         = nfg;
        bgIn       = nbg;
      end
      if (lane == stall_lane) begin
        readyOut = 1'b0;
        repeat (stall_n) begin
          chk_lane(fg, bg, lane);
          @(negedge clk);
        end
        readyOut = 1'b1;
      end
      chk_lane(fg, bg, lane);
      @(negedge clk);
    end
  endtask

  task automatic chk_idle(input string tag);
    validInput = 1'b0;
    #1;
    check({tag, "_vld"}, 32'(validOutput), 32'd0);
    check({tag, "_pix"}, pixel, 32'd0);
    check({tag, "_key"}, 32'(isKey), 32'd0);
    check({tag, "_rdy"}, 32'(inReady), 32'd1);
  endtask

  initial begin
    logic [127:0] g1, g2, g3, b1, b2, b3;
    rst = 1'b1; validInput = 1'b0; in = '0; bgIn = '0; readyOut = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_idle("reset");
    check("reset_kc", 32'(keyCount), 32'd0);
    @(negedge clk);

    // Reference vector: two keyed lanes out of four.
    g1 = {32'h0000FF00, 32'h00FF0000, 32'h0000FF00, 32'h00101010};
    b1 = {4{32'hAA123456}};
    start(g1, b1);
    play_group(g1, b1, 1'b0, '0, '0, -1, 0);
    chk_idle("ref_end");
`ifdef CHROMA_STATS_EN
    check("ref_kc", 32'(keyCount), 32'd2);
`else
    check("ref_kc", 32'(keyCount), 32'd0);
`endif

    // Threshold edges: G == R+40 not keyed, G == R+41 keyed, G just under GREEN_MIN not keyed.
    g1 = {32'h113C643C, 32'h223B643B, 32'h33006300, 32'h44006400};
    b1 = rand_grp();
    start(g1, b1);
    play_group(g1, b1, 1'b0, '0, '0, -1, 0);
    chk_idle("thr_end");

    // Three groups back-to-back with zero bubble.
    g1 = rand_grp(); b1 = rand_grp();
    g2 = rand_grp(); b2 = rand_grp();
    g3 = rand_grp(); b3 = rand_grp();
    start(g1, b1);
    play_group(g1, b1, 1'b1, g2, b2, -1, 0);
    play_group(g2, b2, 1'b1, g3, b3, -1, 0);
    play_group(g3, b3, 1'b0, '0, '0, -1, 0);
    chk_idle("b2b_end");

    // Stall three cycles on lane 1.
    g1 = rand_grp(); b1 = rand_grp();
    start(g1, b1);
    play_group(g1, b1, 1'b0, '0, '0, 1, 3);
    chk_idle("stall_end");

    // Reset right at lane 1's handshake, with a competing validInput.
    g1 = rand_grp(); b1 = rand_grp();
    start(g1, b1);
    validInput = 1'b0;
    chk_lane(g1, b1, 0);
    @(negedge clk);
    chk_lane(g1, b1, 1);
    rst = 1'b1;
    validInput = 1'b1;
    in = rand_grp();
    @(negedge clk);
    rst = 1'b0;
    kc_model = 0;
    chk_idle("rst_mid");
    check("rst_kc", 32'(keyCount), 32'd0);
    @(negedge clk);
    chk_idle("rst_after");
    @(negedge clk);

    // Random traffic with random stalls and chaining.
    g1 = rand_grp(); b1 = rand_grp();
    start(g1, b1);
    for (int n = 0; n < 20; n++) begin
      bit nv;
      nv = (n != 19) && ($urandom_range(0, 2) != 0);
      g2 = rand_grp(); b2 = rand_grp();
      play_group(g1, b1, nv, g2, b2, $urandom_range(0, 4), $urandom_range(1, 3));
      if (!nv) begin
        chk_idle($sformatf("rnd%0d", n));
        if (n != 19) start(g2, b2);
      end
      g1 = g2; b1 = b2;
    end

`ifdef CHROMA_STATS_EN
    // Saturation: every pixel keyed, streamed continuously.
    validInput = 1'b1;
    in   = {4{32'h0000FF00}};
    bgIn = {4{32'h12345678}};
    readyOut = 1'b1;
    repeat (65544) @(negedge clk);
    validInput = 1'b0;
    repeat (8) @(negedge clk);
    check("sat_kc", 32'(keyCount), 32'h0000FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
